mem_access_unit: RTL

//  MEM-stage data-bus master, directly downstream of the EX/MEM pipeline register.

---
 rtl/mem_access_unit_pkg.sv | 31 +++
 rtl/mem_access_unit_load_align.sv | 33 +++
 rtl/mem_access_unit.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared types and constants for the MEM-stage data-bus master.
// State encodings, bus size codes and load byte-mask constants.
package mem_access_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_WAIT   = 2'd2,
    ST_CANCEL = 2'd3
  } mau_state_e;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  localparam logic [3:0] REN_B = 4'b0001;
  localparam logic [3:0] REN_H = 4'b0011;
  localparam logic [3:0] REN_W = 4'b1111;

  // Number of active byte lanes mapped onto the bus size code.
  function automatic logic [1:0] mask_to_size(input logic [3:0] mask);
    logic [2:0] cnt;
    cnt = 3'(mask[0]) + 3'(mask[1]) + 3'(mask[2]) + 3'(mask[3]);
    case (cnt)
      3'd4:    mask_to_size = SIZE_WORD;
      3'd2:    mask_to_size = SIZE_HALF;
      default: mask_to_size = SIZE_BYTE;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// Load data alignment: shifts the addressed lane down to bit 0 and
// zero- or sign-extends byte and halfword loads.
module mem_access_unit_load_align
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [3:0]  ren,
  input  logic        zext,
  output logic [31:0] result
);

  logic [31:0] sh;
  logic        ext;

  always_comb begin
    sh     = rdata >> {addr_lo, 3'b000};
    ext    = 1'b0;
    result = sh;
    case (ren)
      REN_B: begin
        ext    = ~zext & sh[7];
        result = {{24{ext}}, sh[7:0]};
      end
      REN_H: begin
        ext    = ~zext & sh[15];
        result = {{16{ext}}, sh[15:0]};
      end
      default: result = sh;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-bus master: one SRAM-like transaction per load/store,
// pipeline hold while open, registered aligned load result for MEM/WB.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          mem_valid,
  input  logic          mem_ex_any,
  input  logic          flush,
  input  logic          mem_data_en,
  input  logic [3:0]    mem_data_ren,
  input  logic [3:0]    mem_data_wen,
  input  logic [AW-1:0] mem_res,
  input  logic [DW-1:0] mem_wdata,
  input  logic          mem_loadX,
  output logic          data_req,
  output logic          data_wr,
  output logic [1:0]    data_size,
  output logic [AW-1:0] data_addr,
  output logic [3:0]    data_wstrb,
  output logic [DW-1:0] data_wdata,
  input  logic          data_addr_ok,
  input  logic          data_data_ok,
  input  logic [DW-1:0] data_rdata,
  output logic          mem_stall,
  output logic          wb_valid,
  output logic [DW-1:0] wb_rdata
);

  mau_state_e    state_q, state_d;
  logic [AW-1:0] lat_addr_q;
  logic [3:0]    lat_ren_q;
  logic [3:0]    lat_wen_q;
  logic [DW-1:0] lat_wdata_q;
  logic          lat_loadx_q;
  logic          flush_seen_q, flush_seen_d;

  logic          start;
  logic          in_idle;
  logic          latch_en;
  logic          deliver;
  logic [AW-1:0] cur_addr;
  logic [3:0]    cur_ren;
  logic [3:0]    cur_wen;
  logic [DW-1:0] cur_wdata;
  logic          cur_loadx;
  logic          cur_is_read;
  logic [DW-1:0] aligned;

  assign start   = mem_valid & mem_data_en & ~mem_ex_any & ~flush;
  assign in_idle = (state_q == ST_IDLE);

  // Idle: fields come straight from EX/MEM; otherwise from the latched copy.
  assign cur_addr    = in_idle ? mem_res      : lat_addr_q;
  assign cur_ren     = in_idle ? mem_data_ren : lat_ren_q;
  assign cur_wen     = in_idle ? mem_data_wen : lat_wen_q;
  assign cur_wdata   = in_idle ? mem_wdata    : lat_wdata_q;
  assign cur_loadx   = in_idle ? mem_loadX    : lat_loadx_q;
  assign cur_is_read = ~|cur_wen;

  assign data_wr    = |cur_wen;
  assign data_size  = mask_to_size(cur_ren | cur_wen);
  assign data_addr  = cur_addr;
  assign data_wstrb = cur_wen;
  assign data_wdata = cur_wdata;

  mem_access_unit_load_align u_load_align (
    .rdata   (data_rdata),
    .addr_lo (cur_addr[1:0]),
    .ren     (cur_ren),
    .zext    (cur_loadx),
    .result  (aligned)
  );

  // Next state, request, stall and delivery decode.
  always_comb begin
    state_d      = state_q;
    flush_seen_d = flush_seen_q;
    data_req     = 1'b0;
    mem_stall    = 1'b0;
    latch_en     = 1'b0;
    deliver      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        flush_seen_d = 1'b0;
        if (start) begin
          data_req = 1'b1;
          latch_en = 1'b1;
          if (data_addr_ok && data_data_ok) begin
            deliver = cur_is_read;
          end else if (data_addr_ok) begin
            mem_stall = 1'b1;
            state_d   = ST_WAIT;
          end else begin
            mem_stall = 1'b1;
            state_d   = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        data_req  = 1'b1;
        mem_stall = 1'b1;
        if (flush) flush_seen_d = 1'b1;
        if (data_addr_ok) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (data_data_ok) begin
          deliver = cur_is_read & ~(flush | flush_seen_q);
          state_d = ST_IDLE;
        end else begin
          mem_stall = 1'b1;
          if (flush || flush_seen_q) state_d = ST_CANCEL;
        end
      end
      ST_CANCEL: begin
        mem_stall = 1'b1;
        if (data_data_ok) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      flush_seen_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      flush_seen_q <= flush_seen_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      lat_addr_q  <= '0;
      lat_ren_q   <= '0;
      lat_wen_q   <= '0;
      lat_wdata_q <= '0;
      lat_loadx_q <= 1'b0;
    end else if (latch_en) begin
      lat_addr_q  <= mem_res;
      lat_ren_q   <= mem_data_ren;
      lat_wen_q   <= mem_data_wen;
      lat_wdata_q <= mem_wdata;
      lat_loadx_q <= mem_loadX;
    end
  end

  // Load result register toward MEM/WB; data holds between deliveries.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wb_valid <= 1'b0;
      wb_rdata <= '0;
    end else begin
      wb_valid <= deliver;
      if (deliver) wb_rdata <= aligned;
    end
  end

endmodule
